mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port IR_E, input, 32, E-stage instruction word; decoded internally for mult, multu, div, divu, mthi, mtlo.
REQ-004 SHALL have port IR_D, input, 32, D-stage instruction word; used only for stall decision.
REQ-005 SHALL have port A, input, 32, E-stage rs operand.
REQ-006 SHALL have port B, input, 32, E-stage rt operand.
REQ-007 SHALL have port busy, output, 1, multi-cycle operation in progress.
REQ-008 SHALL have port MD_stall, output, 1, stall request to D stage.
REQ-009 SHALL have port MDout, output, 32, mfhi/mflo result for IR_E.
REQ-010 SHALL have parameters MULT_CYCLES, default 5, multiply latency; DIV_CYCLES, default 10, divide latency.

Function
REQ-011 SHALL decode only opcode 6'b000000 with funct 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo; all other words SHALL be no-ops.
REQ-012 SHALL implement a three-state FSM: IDLE, MUL, DIV; busy SHALL be 1 iff state is not IDLE.
REQ-013 In IDLE, mult/multu in IR_E SHALL be the start event: latch 64-bit product of A,B (signed/unsigned) into pending registers, load counter with MULT_CYCLES, go to MUL.
REQ-014 In IDLE, div/divu in IR_E SHALL latch quotient (to LO) and remainder (to HI) into pending registers, load counter with DIV_CYCLES, go to DIV.
REQ-015 Signed divide SHALL truncate toward zero, remainder taking dividend sign; 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-016 Divide by zero SHALL run the full DIV_CYCLES and SHALL leave HI and LO unchanged.
REQ-017 In MUL/DIV the counter SHALL decrement each cycle; on the cycle it equals 1, pending values SHALL be written to HI/LO and state SHALL return to IDLE.
REQ-018 Start at cycle t SHALL give busy high cycles t+1..t+N and new HI/LO visible from t+N+1 (N = configured latency).
REQ-019 Start events and mthi/mtlo in IR_E while busy SHALL be ignored.
REQ-020 mthi/mtlo in IDLE SHALL write A to HI/LO at the next edge.
REQ-021 MDout SHALL combinationally equal HI for mfhi, LO for mflo, else 0.
REQ-022 MD_stall SHALL equal (busy or start event in IR_E) and IR_D decodes as any of the eight MD instructions.
REQ-023 A start event coinciding with the final busy cycle SHALL be ignored (stall guarantees it is never issued).

Reset
REQ-024 On reset: state IDLE, counter 0, HI=0, LO=0, pending registers 0, busy=0, MD_stall=0 unless IR_D/IR_E conditions per REQ-022 with busy=0.
REQ-025 Reset SHALL abort any in-flight operation; pending results SHALL NOT reach HI/LO.

Structure
REQ-026 Funct codes and FSM state encodings SHALL live in the shared MIPS definitions package.
REQ-027 One sub-module SHALL be natural: md_decoder, decoding a 32-bit word into the eight MD strobes, instantiated for IR_E and IR_D.

Verification
REQ-028 mult A=0xFFFFFFFE, B=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-029 div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-030 mthi A=0x12345678 in IDLE then mfhi -> MDout=0x12345678 next cycle; div by zero afterwards -> HI still 0x12345678 after 10 cycles.
REQ-031 mult in E with mflo in D -> MD_stall=1 from start cycle through last busy cycle, 0 in cycle after; MDout then shows new LO.
REQ-032 reset asserted at busy cycle 3 of div -> next cycle busy=0, HI=LO=0, no later update.
REQ-033 mult issued while busy -> ignored, HI/LO reflect only first operation.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared MIPS multiply/divide definitions: funct codes, FSM states, strobes.
// Imported by the MD decoder and the MD control unit.
package mdu_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    typedef struct packed {
        logic mult;
        logic multu;
        logic div;
        logic divu;
        logic mfhi;
        logic mthi;
        logic mflo;
        logic mtlo;
    } md_ops_t;

    function automatic logic any_md(input md_ops_t o);
        return o != '0;
    endfunction

    function automatic logic is_start(input md_ops_t o);
        return o.mult | o.multu | o.div | o.divu;
    endfunction

endpackage

// File: rtl/mdu_ctrl_md_decoder.sv
// Decodes one 32-bit instruction word into the eight MD strobes.
// Only SPECIAL-opcode words with an MD funct produce a strobe.
module md_decoder
    import mdu_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output md_ops_t     ops
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = ir[31:26];
    assign funct         = ir[5:0];
    assign unused_fields = ^ir[25:6];

    always_comb begin
        ops = '0;
        if (opcode == OP_SPECIAL) begin
            unique case (funct)
                F_MULT:  ops.mult  = 1'b1;
                F_MULTU: ops.multu = 1'b1;
                F_DIV:   ops.div   = 1'b1;
                F_DIVU:  ops.divu  = 1'b1;
                F_MFHI:  ops.mfhi  = 1'b1;
                F_MTHI:  ops.mthi  = 1'b1;
                F_MFLO:  ops.mflo  = 1'b1;
                F_MTLO:  ops.mtlo  = 1'b1;
                default: ops       = '0;
            endcase
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MIPS HI/LO multiply-divide unit with fixed-latency busy modelling.
// Results are computed at issue and committed when the counter expires.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_E,
    input  logic [31:0] IR_D,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        MD_stall,
    output logic [31:0] MDout
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_ops_t ops_e;
    md_ops_t ops_d;

    md_decoder u_dec_e (.ir(IR_E), .ops(ops_e));
    md_decoder u_dec_d (.ir(IR_D), .ops(ops_d));

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_wr;
    logic             idle;
    logic             start_mul;
    logic             start_div;
    logic             commit;

    logic [63:0] prod;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        sgn;

    assign idle = (state == S_IDLE);
    assign busy = !idle;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        start_mul = 1'b0;
        start_div = 1'b0;
        commit    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (ops_e.mult || ops_e.multu) begin
                    start_mul = 1'b1;
                    state_nx  = S_MUL;
                end else if (ops_e.div || ops_e.divu) begin
                    start_div = 1'b1;
                    state_nx  = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt == CNT_W'(1)) begin
                    commit   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Signed divide via magnitudes: truncates toward zero and makes
    // 0x80000000 / -1 fall out as 0x80000000 rem 0 without a special case.
    always_comb begin
        sgn   = ops_e.div;
        abs_a = (sgn && A[31]) ? 32'd0 - A : A;
        abs_b = (sgn && B[31]) ? 32'd0 - B : B;
        uq    = (abs_b == '0) ? '0 : abs_a / abs_b;
        ur    = (abs_b == '0) ? '0 : abs_a % abs_b;
        quot  = (sgn && (A[31] ^ B[31])) ? 32'd0 - uq : uq;
        rem   = (sgn && A[31]) ? 32'd0 - ur : ur;
        if (ops_e.mult)
            prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        else
            prod = {32'd0, A} * {32'd0, B};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            if (start_mul) begin
                pend_hi <= prod[63:32];
                pend_lo <= prod[31:0];
                pend_wr <= 1'b1;
                cnt     <= CNT_W'(MULT_CYCLES);
            end else if (start_div) begin
                pend_hi <= rem;
                pend_lo <= quot;
                pend_wr <= (B != '0);
                cnt     <= CNT_W'(DIV_CYCLES);
            end else if (!idle) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (commit && pend_wr) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end else if (idle && ops_e.mthi) begin
                hi <= A;
            end else if (idle && ops_e.mtlo) begin
                lo <= A;
            end
        end
    end

    assign MD_stall = (busy || is_start(ops_e)) && any_md(ops_d);

    always_comb begin
        MDout = '0;
        if (ops_e.mfhi)      MDout = hi;
        else if (ops_e.mflo) MDout = lo;
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (default latencies 5/10).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_E;
    logic [31:0] IR_D;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        MD_stall;
    logic [31:0] MDout;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] MFHI  = 32'h0000_0010;
    localparam logic [31:0] MTHI  = 32'h0000_0011;
    localparam logic [31:0] MFLO  = 32'h0000_0012;
    localparam logic [31:0] MTLO  = 32'h0000_0013;
    localparam logic [31:0] MULT  = 32'h0000_0018;
    localparam logic [31:0] MULTU = 32'h0000_0019;
    localparam logic [31:0] DIV   = 32'h0000_001A;
    localparam logic [31:0] DIVU  = 32'h0000_001B;

    mdu_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .IR_E     (IR_E),
        .IR_D     (IR_D),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .MD_stall (MD_stall),
        .MDout    (MDout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ir, input logic [31:0] a,
                         input logic [31:0] b);
        IR_E = ir;
        A    = a;
        B    = b;
        step();
        IR_E = NOP;
    endtask

    task automatic busy_len(input string tag, input int exp);
        int n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            step();
        end
        check(tag, 32'(n), 32'(exp));
    endtask

    task automatic read_md(input string tag, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
        IR_E = MFHI;
        #1;
        check({tag, "_hi"}, MDout, exp_hi);
        IR_E = MFLO;
        #1;
        check({tag, "_lo"}, MDout, exp_lo);
        IR_E = NOP;
        #1;
        check({tag, "_nop"}, MDout, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        IR_E  = NOP;
        IR_D  = NOP;
        A     = '0;
        B     = '0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_stall", 32'(MD_stall), 32'h0);
        IR_D = MFLO;
        IR_E = MULT;
        #1;
        check("rst_stall_start", 32'(MD_stall), 32'h1);
        IR_D = NOP;
        IR_E = NOP;
        reset = 1'b0;
        step();
        read_md("rst", 32'h0, 32'h0);

        // mult with mflo behind it in D; a second mult while busy is dropped
        IR_D = MFLO;
        IR_E = MULT;
        A    = 32'hFFFF_FFFE;
        B    = 32'd3;
        #1;
        check("mult_stall_t0", 32'(MD_stall), 32'h1);
        check("mult_busy_t0", 32'(busy), 32'h0);
        step();
        IR_E = NOP;
        for (int i = 1; i <= 5; i++) begin
            #1;
            check("mult_busy", 32'(busy), 32'h1);
            check("mult_stall", 32'(MD_stall), 32'h1);
            if (i == 2) begin
                IR_E = MULT;
                A    = 32'd5;
                B    = 32'd5;
            end else begin
                IR_E = NOP;
            end
            step();
        end
        IR_E = NOP;
        #1;
        check("mult_busy_end", 32'(busy), 32'h0);
        check("mult_stall_end", 32'(MD_stall), 32'h0);
        IR_D = NOP;
        read_md("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        issue(MULTU, 32'hFFFF_FFFE, 32'd3);
        busy_len("multu_len", 5);
        read_md("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        busy_len("div_len", 10);
        read_md("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(DIVU, 32'd7, 32'd2);
        busy_len("divu_len", 10);
        read_md("divu", 32'd1, 32'd3);

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        busy_len("div_ovf_len", 10);
        read_md("div_ovf", 32'h0, 32'h8000_0000);

        issue(MTHI, 32'h1234_5678, 32'h0);
        check("mthi_busy", 32'(busy), 32'h0);
        issue(MTLO, 32'hCAFE_F00D, 32'h0);
        read_md("mthilo", 32'h1234_5678, 32'hCAFE_F00D);

        issue(DIV, 32'd5, 32'd0);
        busy_len("div0_len", 10);
        read_md("div0", 32'h1234_5678, 32'hCAFE_F00D);

        // mthi mid-op and mult in the final busy cycle are both dropped
        issue(DIVU, 32'd9, 32'd4);
        for (int i = 2; i <= 10; i++) begin
            IR_E = (i == 3) ? MTHI : NOP;
            A    = 32'hDEAD_BEEF;
            step();
        end
        check("last_busy", 32'(busy), 32'h1);
        IR_E = MULT;
        A    = 32'd2;
        B    = 32'd2;
        step();
        IR_E = NOP;
        check("last_idle", 32'(busy), 32'h0);
        step();
        check("last_no_restart", 32'(busy), 32'h0);
        read_md("last", 32'd1, 32'd2);

        // reset in busy cycle 3 of a divide
        issue(DIV, 32'd100, 32'd7);
        step();
        step();
        check("abort_busy_pre", 32'(busy), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        read_md("abort", 32'h0, 32'h0);
        for (int i = 0; i < 12; i++) step();
        check("abort_busy_late", 32'(busy), 32'h0);
        read_md("abort_late", 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
